// File: rtl/prbs7_pkg.sv
// -----------------------------------------------------------------------------
// prbs7_pkg
// Shared definitions for the parallel PRBS7 (x^7 + x^6 + 1) checker:
//   POLY2 / POLY1 : polynomial tap description (s[i] = s[i+POLY2] ^ s[i+POLY2-POLY1])
//   MAX_W         : widest word the nxt() helper can produce
//   state_t       : checker state (SEARCH / LOCKED)
//   nxt()         : next NBITS-wide word given the previous word's low 7 bits
// -----------------------------------------------------------------------------
package prbs7_pkg;

    localparam int POLY2 = 7;
    localparam int POLY1 = 1;
    localparam int MAX_W = 64;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Only the last 7 bits of a word carry LFSR state. Bits are produced
    // oldest-first, so the first generated bit lands in the word MSB.
    // The result is MAX_W wide; callers size-cast it down to their word width.
    function automatic logic [MAX_W-1:0] nxt(input logic [6:0] w, input int nbits);
        logic [6:0]       r;
        logic [MAX_W-1:0] res;
        logic             b;
        r   = w;
        res = '0;
        b   = 1'b0;
        for (int k = 0; k < MAX_W; k++) begin
            if (k < nbits) begin
                b   = r[POLY2-1] ^ r[POLY2-1-POLY1];
                r   = {r[5:0], b};
                res = {res[MAX_W-2:0], b};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prbs_err_accum.sv
// -----------------------------------------------------------------------------
// prbs_err_accum
// Error/word accumulators for the PRBS7 checker. On every checked word the
// word counter advances by one and the error counter advances by the number of
// differing bits between the received and expected words. Both saturate.
//   clk_i       : clock, rising edge
//   reset_i     : asynchronous active-high reset
//   clear_i     : synchronous clear of both counters (wins over chk_vld_p0)
//   chk_vld_p0  : a word is being checked this cycle
//   data_i      : received word
//   expected_i  : reference word
//   err_cnt_o   : saturating bit-error count
//   word_cnt_o  : saturating checked-word count
// -----------------------------------------------------------------------------
module prbs_err_accum #(
    parameter int NBITS = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             chk_vld_p0,
    input  logic [NBITS-1:0] data_i,
    input  logic [NBITS-1:0] expected_i,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int PC_W  = $clog2(NBITS + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    function automatic logic [PC_W-1:0] popcount(input logic [NBITS-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < NBITS; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    // Add in a widened domain so the carry is visible, then clamp.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return CNT_W'(s);
    endfunction

    logic [PC_W-1:0]  bit_err_p0;
    logic [CNT_W-1:0] err_cnt_p1;
    logic [CNT_W-1:0] word_cnt_p1;

    assign bit_err_p0 = popcount(data_i ^ expected_i);

    // ---- stage p0 -> p1: registered counters ----
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_cnt_p1  <= '0;
            word_cnt_p1 <= '0;
        end else if (clear_i) begin
            err_cnt_p1  <= '0;
            word_cnt_p1 <= '0;
        end else if (chk_vld_p0) begin
            err_cnt_p1  <= sat_add(err_cnt_p1, bit_err_p0);
            word_cnt_p1 <= sat_add(word_cnt_p1, PC_W'(1));
        end
    end

    assign err_cnt_o  = err_cnt_p1;
    assign word_cnt_o = word_cnt_p1;

endmodule

// File: rtl/prbs7_checker_parallel.sv
// -----------------------------------------------------------------------------
// prbs7_checker_parallel
// Self-synchronising parallel PRBS7 checker. In SEARCH it looks for LOCK_CNT
// consecutive valid words that each follow from the previous one; it then
// free-runs an internal reference in LOCKED and counts word/bit errors, falling
// back to SEARCH after UNLOCK_CNT consecutive bad words.
//   clk_i        : clock, rising edge
//   reset_i      : asynchronous active-high reset
//   clear_i      : synchronous clear (back to SEARCH, counters zeroed)
//   data_valid_i : qualifies data_i
//   data_i       : received NBITS-wide word
//   lock_o       : high while LOCKED
//   err_o        : one-cycle pulse per mismatched word checked in LOCKED
//   err_cnt_o    : saturating bit-error count
//   word_cnt_o   : saturating count of words checked in LOCKED
// -----------------------------------------------------------------------------
module prbs7_checker_parallel #(
    parameter int NBITS      = 8,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             data_valid_i,
    input  logic [NBITS-1:0] data_i,
    output logic             lock_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    import prbs7_pkg::*;

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

    state_t             state;
    logic               have_seed;
    // Only the low 7 bits of the previous word determine the next word.
    logic [6:0]         seed;
    logic [NBITS-1:0]   expected;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic               lock_p1;
    logic               err_p1;

    logic [NBITS-1:0]   nxt_seed;
    logic [NBITS-1:0]   nxt_data;
    logic [NBITS-1:0]   nxt_exp;
    logic               seed_match;
    logic               word_err;
    logic               chk_vld_p0;

    assign nxt_seed = NBITS'(nxt(seed, NBITS));
    assign nxt_data = NBITS'(nxt(data_i[6:0], NBITS));
    assign nxt_exp  = NBITS'(nxt(expected[6:0], NBITS));

    // All-zero is a fixed point of the recurrence and must never count.
    assign seed_match = have_seed && (data_i == nxt_seed) && (data_i != '0);
    assign word_err   = (data_i != expected);
    assign chk_vld_p0 = data_valid_i && !clear_i && (state == LOCKED);

    // ---- stage p0 -> p1: FSM and registered flags ----
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= SEARCH;
            have_seed <= 1'b0;
            seed      <= '0;
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            lock_p1   <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            err_p1 <= 1'b0;
            if (clear_i) begin
                state     <= SEARCH;
                have_seed <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                lock_p1   <= 1'b0;
            end else if (data_valid_i) begin
                case (state)
                    SEARCH: begin
                        seed      <= data_i[6:0];
                        have_seed <= 1'b1;
                        if (seed_match) begin
                            if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                                state     <= LOCKED;
                                lock_p1   <= 1'b1;
                                expected  <= nxt_data;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Reference free-runs; a bad word never reseeds it.
                        expected <= nxt_exp;
                        if (word_err) begin
                            err_p1 <= 1'b1;
                            if (miss_cnt == MISS_W'(UNLOCK_CNT - 1)) begin
                                state     <= SEARCH;
                                lock_p1   <= 1'b0;
                                seed      <= data_i[6:0];
                                have_seed <= 1'b1;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    prbs_err_accum #(
        .NBITS (NBITS),
        .CNT_W (CNT_W)
    ) u_accum (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (clear_i),
        .chk_vld_p0 (chk_vld_p0),
        .data_i     (data_i),
        .expected_i (expected),
        .err_cnt_o  (err_cnt_o),
        .word_cnt_o (word_cnt_o)
    );

    assign lock_o = lock_p1;
    assign err_o  = err_p1;

endmodule

// File: tb/tb_prbs7_checker_parallel.sv
module tb_prbs7_checker_parallel;

    logic        clk;
    logic        reset_i;
    logic        clear_i;
    logic        data_valid_i;
    logic [7:0]  data_i;
    logic        lock_o;
    logic        err_o;
    logic [15:0] err_cnt_o;
    logic [15:0] word_cnt_o;
    logic        s_lock;
    logic        s_err;
    logic [3:0]  s_err_cnt;
    logic [3:0]  s_word_cnt;

    int          n_vec;
    int          n_miss;
    logic [7:0]  cur;
    int          exp_err;

    prbs7_checker_parallel #(
        .NBITS(8), .LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(16)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .clear_i      (clear_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .lock_o       (lock_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o),
        .word_cnt_o   (word_cnt_o)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation checks.
    prbs7_checker_parallel #(
        .NBITS(8), .LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(4)
    ) dut_s (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .clear_i      (clear_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .lock_o       (s_lock),
        .err_o        (s_err),
        .err_cnt_o    (s_err_cnt),
        .word_cnt_o   (s_word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference recurrence written directly from s[i] = s[i+7] ^ s[i+6].
    function automatic logic [7:0] nxt_m(input logic [7:0] w);
        logic [14:0] s;
        s = '0;
        s[14:8] = w[6:0];
        for (int i = 7; i >= 0; i--) s[i] = s[i+7] ^ s[i+6];
        return s[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic vld, input logic [7:0] d, input logic clr);
        @(negedge clk);
        data_valid_i = vld;
        data_i       = d;
        clear_i      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean();
        cur = nxt_m(cur);
        step(1'b1, cur, 1'b0);
    endtask

    initial begin
        reset_i = 1'b1; clear_i = 1'b0; data_valid_i = 1'b0; data_i = '0;
        n_vec = 0; n_miss = 0; exp_err = 0; cur = 8'hFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_lock",  32'(lock_o), 0);
        chk("rst_err",   32'(err_o), 0);
        chk("rst_errc",  32'(err_cnt_o), 0);
        chk("rst_wordc", 32'(word_cnt_o), 0);

        // Clean stream: 0xFF seeds, then 16 matches
        @(negedge clk) reset_i = 1'b0;
        step(1'b1, 8'hFF, 1'b0);
        chk("seed_lock", 32'(lock_o), 0);
        for (int i = 1; i <= 15; i++) begin
            send_clean();
            chk("early_lock", 32'(lock_o), 0);
        end
        send_clean();
        chk("lock_17", 32'(lock_o), 1);
        chk("lock_errc", 32'(err_cnt_o), 0);
        chk("lock_wordc", 32'(word_cnt_o), 0);
        for (int i = 0; i < 5; i++) begin
            send_clean();
            chk("clean_err", 32'(err_o), 0);
        end
        chk("clean_wordc", 32'(word_cnt_o), 5);
        chk("clean_errc", 32'(err_cnt_o), 0);

        // Single-bit error on bit 3
        cur = nxt_m(cur);
        step(1'b1, cur ^ 8'h08, 1'b0);
        chk("bit3_err", 32'(err_o), 1);
        chk("bit3_errc", 32'(err_cnt_o), 1);
        chk("bit3_wordc", 32'(word_cnt_o), 6);
        chk("bit3_lock", 32'(lock_o), 1);
        send_clean();
        chk("after_err", 32'(err_o), 0);
        chk("after_errc", 32'(err_cnt_o), 1);
        chk("after_lock", 32'(lock_o), 1);
        chk("after_wordc", 32'(word_cnt_o), 7);

        // Burst loss: 4 all-zero words (never a legal PRBS7 byte)
        exp_err = 1;
        for (int i = 0; i < 4; i++) begin
            cur = nxt_m(cur);
            exp_err += $countones(cur);
            step(1'b1, 8'h00, 1'b0);
            chk("burst_err", 32'(err_o), 1);
            chk("burst_lock", 32'(lock_o), (i < 3) ? 1 : 0);
        end
        chk("burst_errc", 32'(err_cnt_o), 32'(exp_err));
        chk("burst_wordc", 32'(word_cnt_o), 11);
        for (int i = 0; i < 16; i++) send_clean();
        chk("relock_early", 32'(lock_o), 0);
        send_clean();
        chk("relock", 32'(lock_o), 1);
        chk("relock_errc", 32'(err_cnt_o), 32'(exp_err));
        chk("relock_wordc", 32'(word_cnt_o), 11);

        // Gaps between valid words
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
            chk("gap_err", 32'(err_o), 0);
            send_clean();
            chk("gap_lock", 32'(lock_o), 1);
        end
        chk("gap_wordc", 32'(word_cnt_o), 17);
        chk("gap_errc", 32'(err_cnt_o), 32'(exp_err));
        chk("sat_wordc", 32'(s_word_cnt), 15);

        // Clear together with a valid word
        step(1'b1, nxt_m(cur), 1'b1);
        chk("clr_lock", 32'(lock_o), 0);
        chk("clr_errc", 32'(err_cnt_o), 0);
        chk("clr_wordc", 32'(word_cnt_o), 0);
        chk("clr_err", 32'(err_o), 0);

        // All-zero input never locks
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'h00, 1'b0);
            chk("zero_lock", 32'(lock_o), 0);
        end
        chk("zero_errc", 32'(err_cnt_o), 0);

        // Relock, then saturate the 4-bit error counter
        send_clean();
        for (int i = 0; i < 16; i++) send_clean();
        chk("lock2", 32'(lock_o), 1);
        for (int i = 0; i < 3; i++) begin
            cur = nxt_m(cur);
            step(1'b1, ~cur, 1'b0);
            chk("inv_err", 32'(err_o), 1);
            chk("inv_lock", 32'(lock_o), 1);
            chk("inv_errc", 32'(err_cnt_o), 32'(8 * (i + 1)));
            chk("sat_errc", 32'(s_err_cnt), (i == 0) ? 8 : 15);
        end
        chk("sat_wordc3", 32'(s_word_cnt), 3);

        // Asynchronous reset mid-stream, no clock edge needed
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk("arst_lock", 32'(lock_o), 0);
        chk("arst_err", 32'(err_o), 0);
        chk("arst_errc", 32'(err_cnt_o), 0);
        chk("arst_wordc", 32'(word_cnt_o), 0);
        chk("arst_serrc", 32'(s_err_cnt), 0);
        @(negedge clk) reset_i = 1'b0;
        send_clean();
        chk("arst_seed", 32'(lock_o), 0);
        for (int i = 0; i < 15; i++) send_clean();
        chk("arst_early", 32'(lock_o), 0);
        send_clean();
        chk("arst_relock", 32'(lock_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
